// File: rtl/sync_upcount_ctl.sv
// Up-counter with IDLE/RUN/DONE control: one-shot or wrapping runs to MAX,
// synchronous clamped parallel load, sticky wrap flag.
module sync_upcount_ctl #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             at_max;

  assign at_max = (cnt_q == MAX_V);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: every next-state signal is given its hold value first so no path
  // through the branches leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (load) begin
      // Clamp keeps the count inside 0..MAX even for out-of-range loads.
      cnt_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (start) begin
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN && en) begin
      if (!at_max) begin
        cnt_d = cnt_q + 1'b1;
      end else if (oneshot) begin
        state_d = DONE;
      end else begin
        cnt_d = '0;
        ovf_d = 1'b1;
      end
    end
  end

  assign q    = cnt_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign tc   = busy && at_max;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_sync_upcount_ctl.sv
// Directed bench for sync_upcount_ctl: vector table for the main sequence,
// hand-written sequences for full runs, wrap, async reset and load clamping.
module tb_sync_upcount_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  // Instance A: default WIDTH=4, MAX=15
  logic       start = 0, en = 0, oneshot = 0, load = 0;
  logic [3:0] load_val = '0;
  logic [3:0] q;
  logic       busy, tc, done, ovf;

  // Instance B: WIDTH=5, MAX=12 for clamping checks
  logic       b_start = 0, b_en = 0, b_oneshot = 0, b_load = 0;
  logic [4:0] b_load_val = '0;
  logic [4:0] b_q;
  logic       b_busy, b_tc, b_done, b_ovf;

  int checks = 0;
  int errors = 0;

  sync_upcount_ctl #(.WIDTH(4), .MAX(15)) u_a (
    .clk(clk), .rst(rst), .start(start), .en(en), .oneshot(oneshot),
    .load(load), .load_val(load_val), .q(q), .busy(busy), .tc(tc),
    .done(done), .ovf(ovf)
  );

  sync_upcount_ctl #(.WIDTH(5), .MAX(12)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .en(b_en), .oneshot(b_oneshot),
    .load(b_load), .load_val(b_load_val), .q(b_q), .busy(b_busy), .tc(b_tc),
    .done(b_done), .ovf(b_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start, en, oneshot, load;
    logic [3:0] lv;
    logic [3:0] q;
    logic       busy, tc, done, ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic e, logic os, logic ld, logic [3:0] lv,
                              logic [3:0] eq, logic eb, logic et, logic ed, logic eo);
    vec_t v;
    v.start = s; v.en = e; v.oneshot = os; v.load = ld; v.lv = lv;
    v.q = eq; v.busy = eb; v.tc = et; v.done = ed; v.ovf = eo;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_a(string tag, logic [3:0] eq, logic eb, logic et, logic ed, logic eo);
    check({tag, ".q"},    int'(q),    int'(eq));
    check({tag, ".busy"}, int'(busy), int'(eb));
    check({tag, ".tc"},   int'(tc),   int'(et));
    check({tag, ".done"}, int'(done), int'(ed));
    check({tag, ".ovf"},  int'(ovf),  int'(eo));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(logic s, logic e, logic os, logic ld, logic [3:0] lv);
    start = s; en = e; oneshot = os; load = ld; load_val = lv;
  endtask

  initial begin
    // start, en, oneshot, load, load_val | q, busy, tc, done, ovf
    vecs.push_back(mk(0,0,0,0, 0,   0, 0,0,0,0)); // idle holds
    vecs.push_back(mk(1,0,0,1, 9,   9, 0,0,0,0)); // load beats start, stays IDLE
    vecs.push_back(mk(0,1,0,0, 0,   9, 0,0,0,0)); // en ignored in IDLE
    vecs.push_back(mk(1,1,0,0, 0,   0, 1,0,0,0)); // start -> RUN, q=0
    vecs.push_back(mk(0,1,0,0, 0,   1, 1,0,0,0));
    vecs.push_back(mk(0,1,0,0, 0,   2, 1,0,0,0));
    vecs.push_back(mk(0,1,0,0, 0,   3, 1,0,0,0));
    vecs.push_back(mk(0,1,0,0, 0,   4, 1,0,0,0));
    vecs.push_back(mk(0,1,0,0, 0,   5, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,   5, 1,0,0,0)); // en low 3 cycles
    vecs.push_back(mk(0,0,0,0, 0,   5, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,   5, 1,0,0,0));
    vecs.push_back(mk(0,1,0,0, 0,   6, 1,0,0,0)); // resumes at 6
    vecs.push_back(mk(0,1,0,1, 14, 14, 1,0,0,0)); // load beats count
    vecs.push_back(mk(0,1,1,0, 0,  15, 1,1,0,0)); // reach MAX, tc
    vecs.push_back(mk(0,1,1,0, 0,  15, 0,0,1,0)); // oneshot -> DONE
    vecs.push_back(mk(0,1,0,0, 0,  15, 0,0,1,0)); // DONE holds
    vecs.push_back(mk(0,0,0,1, 3,   3, 0,0,1,0)); // load in DONE keeps state
    vecs.push_back(mk(1,0,0,0, 0,   0, 1,0,0,0)); // restart from DONE
    vecs.push_back(mk(0,0,0,1, 15, 15, 1,1,0,0)); // load MAX in RUN
    vecs.push_back(mk(0,1,0,0, 0,   0, 1,0,0,1)); // wrap sets ovf
    vecs.push_back(mk(0,1,0,0, 0,   1, 1,0,0,1)); // ovf sticky
    vecs.push_back(mk(1,1,0,0, 0,   0, 1,0,0,0)); // restart in RUN clears ovf

    // Reset asserted at time 0: outputs must already be cleared.
    #1;
    check_a("reset", 0, 0, 0, 0, 0);
    #12 rst = 1'b1;
    tick();
    check_a("post_reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_a(vecs[i].start, vecs[i].en, vecs[i].oneshot, vecs[i].load, vecs[i].lv);
      tick();
      check_a($sformatf("vec%0d", i), vecs[i].q, vecs[i].busy, vecs[i].tc,
              vecs[i].done, vecs[i].ovf);
    end

    // Full one-shot run 0..15 then DONE.
    drive_a(0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    tick();
    drive_a(1, 0, 1, 0, 0);
    tick();
    check_a("run_start", 0, 1, 0, 0, 0);
    drive_a(0, 1, 1, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check_a($sformatf("run_q%0d", k), 4'(k), 1, (k == 15), 0, 0);
    end
    tick();
    check_a("run_done", 15, 0, 0, 1, 0);
    tick();
    check_a("run_done_hold", 15, 0, 0, 1, 0);

    // Wrapping run: 20 enabled cycles after start.
    drive_a(1, 0, 0, 0, 0);
    tick();
    check_a("wrap_start", 0, 1, 0, 1'b0, 0);
    drive_a(0, 1, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_a($sformatf("wrap_k%0d", k), 4'(k % 16), 1, ((k % 16) == 15), 0, (k >= 16));
    end

    // Async reset between edges while q=7 in RUN.
    drive_a(1, 0, 0, 0, 0);
    tick();
    drive_a(0, 1, 1, 0, 0);
    for (int k = 0; k < 7; k++) tick();
    check_a("abort_pre", 7, 1, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    check_a("abort_async", 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    tick();
    check_a("abort_resume", 0, 0, 0, 0, 0);
    drive_a(0, 0, 0, 0, 0);

    // Clamp on a WIDTH=5, MAX=12 instance.
    b_start = 1;
    tick();
    b_start = 0;
    check("b_start.busy", int'(b_busy), 1);
    b_load = 1; b_load_val = 5'd20;
    tick();
    b_load = 0;
    check("b_clamp.q", int'(b_q), 12);
    check("b_clamp.tc", int'(b_tc), 1);
    b_en = 1; b_oneshot = 0;
    tick();
    check("b_wrap.q", int'(b_q), 0);
    check("b_wrap.ovf", int'(b_ovf), 1);
    b_en = 0; b_load = 1; b_load_val = 5'd11;
    tick();
    b_load = 0;
    check("b_load11.q", int'(b_q), 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_upcount_ctl.md
SYNC_UPCOUNT_CTL -- requirements
Module: sync_upcount_ctl

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; legal range 2..16.
REQ-002 Parameter MAX, default 15, terminal count value; SHALL satisfy 1 <= MAX <= 2^WIDTH-1.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 start  input  1  begin a count run from 0.
REQ-006 en  input  1  count enable; q advances only when en=1 in RUN.
REQ-007 oneshot  input  1  1: stop at MAX; 0: wrap to 0 and continue.
REQ-008 load  input  1  synchronous parallel load of q.
REQ-009 load_val  input  WIDTH  value for load.
REQ-010 q  output  WIDTH  current count, registered.
REQ-011 busy  output  1  1 while FSM is in RUN.
REQ-012 tc  output  1  terminal count: 1 when busy=1 and q==MAX, combinational from registered state.
REQ-013 done  output  1  1 while FSM is in DONE.
REQ-014 ovf  output  1  sticky wrap flag.

Function
REQ-015 FSM states IDLE, RUN, DONE; busy and done decoded from state only.
REQ-016 Priority per cycle: load > start > count.
REQ-017 load=1: q <= min(load_val, MAX) next edge; state, ovf unchanged.
REQ-018 IDLE, start=1, load=0: q <= 0, ovf <= 0, state -> RUN.
REQ-019 IDLE, start=0, load=0: q holds, state holds.
REQ-020 RUN, en=0, load=0, start=0: q and state hold.
REQ-021 RUN, en=1, q<MAX: q <= q+1.
REQ-022 RUN, en=1, q==MAX, oneshot=1: q holds MAX, state -> DONE.
REQ-023 RUN, en=1, q==MAX, oneshot=0: q <= 0, ovf <= 1, state stays RUN.
REQ-024 RUN, start=1, load=0: q <= 0, ovf <= 0, state stays RUN (restart).
REQ-025 DONE: q holds; start=1 -> q <= 0, ovf <= 0, state -> RUN; otherwise holds.
REQ-026 oneshot sampled every cycle; changing it mid-run affects only the next MAX-reached event.
REQ-027 Increment never exceeds MAX; q is never observed > MAX after reset.
REQ-028 Latency: start to first increment = 1 cycle after entering RUN (q=0 at first RUN cycle, q=1 next edge if en=1).

Reset
REQ-029 rst=0 asynchronously forces state IDLE, q=0, ovf=0; hence busy=0, tc=0, done=0 without a clock edge.
REQ-030 Reset deassertion is taken synchronously by the integrator; block resumes at IDLE on first edge with rst=1.
REQ-031 rst=0 mid-run aborts immediately; no done or ovf produced.

Verification
REQ-032 Reset then start=1 one cycle, en=1, oneshot=1, MAX=15 -> q 0..15 over 16 cycles, tc=1 at q=15, next edge done=1, busy=0, q=15 held.
REQ-033 oneshot=0, en=1 for 20 cycles after start -> q wraps 15->0, ovf=1 from wrap edge onward, busy stays 1.
REQ-034 In RUN q=5, drop en 3 cycles -> q stays 5, then resumes 6.
REQ-035 load=1, start=1 same cycle, load_val=9 -> q=9, state unchanged; load_val=20 with WIDTH=5, MAX=12 -> q=12.
REQ-036 In DONE assert start -> q=0, ovf=0, busy=1 next edge.
REQ-037 rst=0 between clock edges while q=7 in RUN -> q=0, busy=0, tc=0 immediately.
